// File: rtl/reg_bridge_pkg.sv
// reg_bridge_pkg: shared FSM state enum, command/status bit positions
// and default frame magics. R_CSUM exists only with REG_BRIDGE_CSUM_EN.
package reg_bridge_pkg;

    localparam int CMD_WR_BIT      = 0;
    localparam int CMD_FIX_BIT     = 1;
    localparam int STAT_BUSTO_BIT  = 0;
    localparam int STAT_BADCMD_BIT = 1;

    localparam logic [7:0] DEF_REQ_MAGIC = 8'hAA;
    localparam logic [7:0] DEF_RPL_MAGIC = 8'hAB;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        CNT,
        ADDR,
        WDATA,
        BUS,
        R_MAGIC,
        R_DATA,
        R_STATUS
`ifdef REG_BRIDGE_CSUM_EN
        ,R_CSUM
`endif
    } state_e;

endpackage

// File: rtl/reg_bridge_timer.sv
// reg_bridge_timer: loadable down-counter, expire_o on the TIMEOUT-th
// enabled cycle after load. Ports: clk_i, reset_ni, load_i, en_i, expire_o.
module reg_bridge_timer
    import reg_bridge_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic load_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire_o = 1'b0;
        end else begin : g_on
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk_i or negedge reset_ni) begin
                if (!reset_ni) begin
                    cnt_q <= '0;
                end else if (load_i) begin
                    cnt_q <= CW'(TIMEOUT);
                end else if (en_i && cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end

            assign expire_o = en_i && !load_i && (cnt_q == CW'(1));
        end
    endgenerate

endmodule

// File: rtl/reg_bridge.sv
// reg_bridge: framed byte-stream host commands -> req/ack register bus,
// framed reply on omux. Host: in_rdy_i/in_data_i; reply: omux_req_o/
// omux_data_o/omux_sel_i; bus: reg_req_o/we/addr/wdata/rdata/ack.
// Optional trailing XOR checksum byte: define REG_BRIDGE_CSUM_EN.
module reg_bridge
    import reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_BYTES  = 2,
    parameter int unsigned DATA_BYTES  = 4,
    parameter logic [7:0]  REQ_MAGIC   = DEF_REQ_MAGIC,
    parameter logic [7:0]  RPL_MAGIC   = DEF_RPL_MAGIC,
    parameter int unsigned RX_TIMEOUT  = 1024,
    parameter int unsigned BUS_TIMEOUT = 64,
    localparam int AW = 8 * ADDR_BYTES,
    localparam int DW = 8 * DATA_BYTES
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          in_rdy_i,
    input  logic [7:0]    in_data_i,
    output logic          omux_req_o,
    output logic [7:0]    omux_data_o,
    input  logic          omux_sel_i,
    output logic          reg_req_o,
    output logic          reg_we_o,
    output logic [AW-1:0] reg_addr_o,
    output logic [DW-1:0] reg_wdata_o,
    input  logic [DW-1:0] reg_rdata_i,
    input  logic          reg_ack_i
);

    state_e        state_q, state_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [7:0]    word_q, word_d;
    logic [1:0]    idx_q, idx_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] data_q, data_d;
    logic [1:0]    stat_q, stat_d;
    logic          req_q, req_d;
`ifdef REG_BRIDGE_CSUM_EN
    logic [7:0]    csum_q, csum_d;
`endif

    logic       rx_state, rx_exp, bus_exp, bus_fin;
    logic       last_word, last_abyte, last_dbyte;
    logic [7:0] rd_byte, stat_byte;

    assign rx_state   = (state_q == CMD) || (state_q == CNT) ||
                        (state_q == ADDR) || (state_q == WDATA);
    assign last_word  = (word_q == cnt_q);
    assign last_abyte = (idx_q == 2'(ADDR_BYTES - 1));
    assign last_dbyte = (idx_q == 2'(DATA_BYTES - 1));
    assign rd_byte    = data_q[8*idx_q +: 8];
    assign stat_byte  = {6'b0, stat_q};

    reg_bridge_timer #(.TIMEOUT(RX_TIMEOUT)) u_rx_tmr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   (in_rdy_i),
        .en_i     (rx_state && !in_rdy_i),
        .expire_o (rx_exp)
    );

    // Loaded on the cycle before req rises; counts req-high cycles.
    reg_bridge_timer #(.TIMEOUT(BUS_TIMEOUT)) u_bus_tmr (
        .clk_i    (clk_i),
        .reset_ni (reset_ni),
        .load_i   ((state_q == BUS) && !req_q && !stat_q[STAT_BUSTO_BIT]),
        .en_i     (req_q && !reg_ack_i),
        .expire_o (bus_exp)
    );

    always_comb begin
        state_d = state_q;
        cmd_d   = cmd_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        idx_d   = idx_q;
        addr_d  = addr_q;
        data_d  = data_q;
        stat_d  = stat_q;
        req_d   = req_q;
        bus_fin = 1'b0;
`ifdef REG_BRIDGE_CSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_rdy_i && in_data_i == REQ_MAGIC) begin
                    stat_d  = '0;
                    state_d = CMD;
                end
            end
            CMD: begin
                if (in_rdy_i) begin
                    if (|in_data_i[7:2]) begin
                        stat_d[STAT_BADCMD_BIT] = 1'b1;
                        state_d = R_MAGIC;
                    end else begin
                        cmd_d   = in_data_i[1:0];
                        state_d = CNT;
                    end
                end else if (rx_exp) begin
                    state_d = IDLE;
                end
            end
            CNT: begin
                if (in_rdy_i) begin
                    cnt_d   = in_data_i;
                    word_d  = '0;
                    idx_d   = '0;
                    state_d = ADDR;
                end else if (rx_exp) begin
                    state_d = IDLE;
                end
            end
            ADDR: begin
                if (in_rdy_i) begin
                    addr_d[8*idx_q +: 8] = in_data_i;
                    if (last_abyte) begin
                        idx_d   = '0;
                        state_d = cmd_q[CMD_WR_BIT] ? WDATA : R_MAGIC;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (rx_exp) begin
                    state_d = IDLE;
                end
            end
            WDATA: begin
                if (in_rdy_i) begin
                    data_d[8*idx_q +: 8] = in_data_i;
                    if (last_dbyte) begin
                        idx_d   = '0;
                        state_d = BUS;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end else if (rx_exp) begin
                    state_d = IDLE;
                end
            end
            BUS: begin
                // After a timeout the word passes through with no bus cycle.
                if (stat_q[STAT_BUSTO_BIT]) begin
                    bus_fin = 1'b1;
                    if (!cmd_q[CMD_WR_BIT]) data_d = '0;
                end else if (!req_q) begin
                    req_d = 1'b1;
                end else if (reg_ack_i) begin
                    req_d   = 1'b0;
                    bus_fin = 1'b1;
                    if (!cmd_q[CMD_WR_BIT]) data_d = reg_rdata_i;
                end else if (bus_exp) begin
                    req_d   = 1'b0;
                    bus_fin = 1'b1;
                    stat_d[STAT_BUSTO_BIT] = 1'b1;
                    if (!cmd_q[CMD_WR_BIT]) data_d = '0;
                end
                if (bus_fin) begin
                    if (!cmd_q[CMD_FIX_BIT]) addr_d = addr_q + 1'b1;
                    idx_d = '0;
                    if (cmd_q[CMD_WR_BIT]) begin
                        word_d  = word_q + 8'd1;
                        state_d = last_word ? R_MAGIC : WDATA;
                    end else begin
                        state_d = R_DATA;
                    end
                end
            end
            R_MAGIC: begin
                if (omux_sel_i) begin
`ifdef REG_BRIDGE_CSUM_EN
                    csum_d = '0;
`endif
                    if (cmd_q[CMD_WR_BIT] || stat_q[STAT_BADCMD_BIT])
                        state_d = R_STATUS;
                    else
                        state_d = BUS;
                end
            end
            R_DATA: begin
                if (omux_sel_i) begin
`ifdef REG_BRIDGE_CSUM_EN
                    csum_d = csum_q ^ rd_byte;
`endif
                    if (last_dbyte) begin
                        idx_d   = '0;
                        word_d  = word_q + 8'd1;
                        state_d = last_word ? R_STATUS : BUS;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end
            R_STATUS: begin
                if (omux_sel_i) begin
`ifdef REG_BRIDGE_CSUM_EN
                    csum_d  = csum_q ^ stat_byte;
                    state_d = R_CSUM;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef REG_BRIDGE_CSUM_EN
            R_CSUM: begin
                if (omux_sel_i) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            cnt_q   <= '0;
            word_q  <= '0;
            idx_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            stat_q  <= '0;
            req_q   <= 1'b0;
`ifdef REG_BRIDGE_CSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            stat_q  <= stat_d;
            req_q   <= req_d;
`ifdef REG_BRIDGE_CSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    always_comb begin
        omux_req_o  = 1'b0;
        omux_data_o = 8'h00;
        case (state_q)
            R_MAGIC: begin
                omux_req_o  = 1'b1;
                omux_data_o = RPL_MAGIC;
            end
            R_DATA: begin
                omux_req_o  = 1'b1;
                omux_data_o = rd_byte;
            end
            R_STATUS: begin
                omux_req_o  = 1'b1;
                omux_data_o = stat_byte;
            end
`ifdef REG_BRIDGE_CSUM_EN
            R_CSUM: begin
                omux_req_o  = 1'b1;
                omux_data_o = csum_q;
            end
`endif
            default: ;
        endcase
    end

    assign reg_req_o   = req_q;
    assign reg_we_o    = req_q && cmd_q[CMD_WR_BIT];
    assign reg_addr_o  = addr_q;
    assign reg_wdata_o = data_q;

endmodule

// File: tb/tb_reg_bridge.sv
// tb_reg_bridge: table-driven frames with reply/bus scoreboards plus
// hand sequences for bus timeout, rx timeout, stalls and async reset.
module tb_reg_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_rdy_i;
    logic [7:0]  in_data_i;
    logic        omux_req_o;
    logic [7:0]  omux_data_o;
    logic        omux_sel_i;
    logic        reg_req_o;
    logic        reg_we_o;
    logic [15:0] reg_addr_o;
    logic [31:0] reg_wdata_o;
    logic [31:0] reg_rdata_i;
    logic        reg_ack_i;

    always #5 clk = ~clk;

    reg_bridge dut (
        .clk_i       (clk),
        .reset_ni    (rst_n),
        .in_rdy_i    (in_rdy_i),
        .in_data_i   (in_data_i),
        .omux_req_o  (omux_req_o),
        .omux_data_o (omux_data_o),
        .omux_sel_i  (omux_sel_i),
        .reg_req_o   (reg_req_o),
        .reg_we_o    (reg_we_o),
        .reg_addr_o  (reg_addr_o),
        .reg_wdata_o (reg_wdata_o),
        .reg_rdata_i (reg_rdata_i),
        .reg_ack_i   (reg_ack_i)
    );

    localparam int NOACK = -1;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          delay;
    } bus_t;

    typedef struct {
        int           nreq;
        logic [127:0] req;
        logic [15:0]  gap;
        int           nrpl;
        logic [127:0] rpl;
        int           nbus;
        bus_t         bus [3];
    } vec_t;

    bus_t       bus_q [$];
    logic [7:0] rpl_q [$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         stall = 0;
    vec_t       vt [6];

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic bus_t mk_bus(logic we, logic [15:0] a,
                                    logic [31:0] wd, logic [31:0] rd,
                                    int dl);
        bus_t b;
        b.we = we;
        b.addr = a;
        b.wdata = wd;
        b.rdata = rd;
        b.delay = dl;
        return b;
    endfunction

    // Reply sink: consumes bytes after `stall` held cycles each.
    initial begin : sink
        int sc;
        sc = 0;
        omux_sel_i = 1'b0;
        forever begin
            @(negedge clk);
            omux_sel_i = 1'b0;
            if (!omux_req_o) begin
                check("idle_zero", omux_data_o, 8'h00);
                sc = 0;
            end else if (rpl_q.size() == 0) begin
                check("extra_reply_req", omux_req_o, 1'b0);
                omux_sel_i = 1'b1;
            end else if (sc < stall) begin
                check("reply_hold", omux_data_o, rpl_q[0]);
                sc++;
            end else begin
                check("reply", omux_data_o, rpl_q.pop_front());
                omux_sel_i = 1'b1;
                sc = 0;
            end
        end
    end

    // Bus responder: checks each access, acks after its delay.
    initial begin : resp
        int   hi;
        bus_t cur;
        hi = 0;
        cur = mk_bus(1'b0, 16'h0, 32'h0, 32'h0, 0);
        reg_ack_i = 1'b0;
        reg_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            reg_ack_i = 1'b0;
            if (reg_req_o) begin
                if (hi == 0) begin
                    if (bus_q.size() == 0) begin
                        check("extra_bus_req", reg_req_o, 1'b0);
                        cur.delay = NOACK;
                    end else begin
                        cur = bus_q.pop_front();
                        check("bus_we", reg_we_o, cur.we);
                        check("bus_addr", reg_addr_o, cur.addr);
                        if (cur.we) check("bus_wdata", reg_wdata_o, cur.wdata);
                    end
                end
                hi++;
                if (cur.delay != NOACK && hi == cur.delay) begin
                    reg_rdata_i = cur.rdata;
                    reg_ack_i = 1'b1;
                end
            end else begin
                if (hi != 0 && cur.delay == NOACK) check("bus_to_len", hi, 64);
                hi = 0;
            end
        end
    end

    task automatic send(logic [127:0] f, int n, logic [15:0] gap);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_rdy_i = 1'b1;
            in_data_i = f[8*(n-1-i) +: 8];
            if (gap[i]) begin
                @(negedge clk);
                in_rdy_i = 1'b0;
                in_data_i = 8'h00;
                repeat (10) @(negedge clk);
            end
        end
        @(negedge clk);
        in_rdy_i = 1'b0;
        in_data_i = 8'h00;
    endtask

    task automatic expect_reply(logic [127:0] r, int n);
`ifdef REG_BRIDGE_CSUM_EN
        logic [7:0] cs = 8'h00;
`endif
        for (int i = 0; i < n; i++) begin
            rpl_q.push_back(r[8*(n-1-i) +: 8]);
`ifdef REG_BRIDGE_CSUM_EN
            if (i > 0) cs = cs ^ r[8*(n-1-i) +: 8];
`endif
        end
`ifdef REG_BRIDGE_CSUM_EN
        rpl_q.push_back(cs);
`endif
    endtask

    task automatic drain(string nm);
        int c = 0;
        while ((rpl_q.size() != 0 || bus_q.size() != 0) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        repeat (20) @(negedge clk);
        check({nm, "_drain"}, rpl_q.size() + bus_q.size(), 0);
    endtask

    task automatic run_vec(vec_t v, string nm);
        for (int b = 0; b < v.nbus; b++) bus_q.push_back(v.bus[b]);
        expect_reply(v.rpl, v.nrpl);
        send(v.req, v.nreq, v.gap);
        drain(nm);
    endtask

    function automatic logic [63:0] outs();
        return {omux_req_o, omux_data_o, reg_req_o, reg_we_o,
                reg_addr_o, reg_wdata_o};
    endfunction

    initial begin : main
        int c;
        vt[0].nreq = 5;  vt[0].req = {8'hAA, 8'h00, 8'h00, 8'h34, 8'h12};
        vt[0].gap = 16'h0;
        vt[0].nrpl = 6;  vt[0].rpl = {8'hAB, 32'hEFBEADDE, 8'h00};
        vt[0].nbus = 1;
        vt[0].bus[0] = mk_bus(1'b0, 16'h1234, 32'h0, 32'hDEADBEEF, 3);

        vt[1].nreq = 13;
        vt[1].req = {8'hAA, 8'h01, 8'h01, 8'hFF, 8'hFF,
                     32'h11223344, 32'h55667788};
        vt[1].gap = 16'h0100;
        vt[1].nrpl = 2;  vt[1].rpl = {8'hAB, 8'h00};
        vt[1].nbus = 2;
        vt[1].bus[0] = mk_bus(1'b1, 16'hFFFF, 32'h44332211, 32'h0, 2);
        vt[1].bus[1] = mk_bus(1'b1, 16'h0000, 32'h88776655, 32'h0, 1);

        vt[2].nreq = 5;  vt[2].req = {8'hAA, 8'h02, 8'h02, 8'h10, 8'h00};
        vt[2].gap = 16'h0;
        vt[2].nrpl = 14;
        vt[2].rpl = {8'hAB, 32'h01000000, 32'h02000000, 32'h03000000, 8'h00};
        vt[2].nbus = 3;
        vt[2].bus[0] = mk_bus(1'b0, 16'h0010, 32'h0, 32'h1, 1);
        vt[2].bus[1] = mk_bus(1'b0, 16'h0010, 32'h0, 32'h2, 2);
        vt[2].bus[2] = mk_bus(1'b0, 16'h0010, 32'h0, 32'h3, 3);

        vt[3].nreq = 2;  vt[3].req = {8'hAA, 8'h80};
        vt[3].gap = 16'h0;
        vt[3].nrpl = 2;  vt[3].rpl = {8'hAB, 8'h02};
        vt[3].nbus = 0;

        vt[4].nreq = 14;
        vt[4].req = {8'h55, 8'hAA, 8'h03, 8'h01, 8'h34, 8'h12,
                     32'hA1A2A3A4, 32'hB1B2B3B4};
        vt[4].gap = 16'h0200;
        vt[4].nrpl = 2;  vt[4].rpl = {8'hAB, 8'h00};
        vt[4].nbus = 2;
        vt[4].bus[0] = mk_bus(1'b1, 16'h1234, 32'hA4A3A2A1, 32'h0, 1);
        vt[4].bus[1] = mk_bus(1'b1, 16'h1234, 32'hB4B3B2B1, 32'h0, 2);

        vt[5].nreq = 2;  vt[5].req = {8'hAA, 8'h04};
        vt[5].gap = 16'h0;
        vt[5].nrpl = 2;  vt[5].rpl = {8'hAB, 8'h02};
        vt[5].nbus = 0;

        rst_n = 1'b0;
        in_rdy_i = 1'b0;
        in_data_i = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_outs", outs(), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 6; k++) run_vec(vt[k], $sformatf("vec%0d", k));

        bus_q.push_back(mk_bus(1'b0, 16'h2000, 32'h0, 32'h0, NOACK));
        expect_reply({8'hAB, 64'h0, 8'h01}, 10);
        send({8'hAA, 8'h00, 8'h01, 8'h00, 8'h20}, 5, 16'h0);
        drain("bus_timeout");

        send({8'hAA, 8'h00, 8'h00}, 3, 16'h0);
        repeat (1023) @(negedge clk);
        send({8'h34, 8'h12}, 2, 16'h0);
        drain("rx_timeout");
        run_vec(vt[0], "after_rx_to");

        bus_q.push_back(vt[0].bus[0]);
        expect_reply(vt[0].rpl, vt[0].nrpl);
        send({8'hAA, 8'h00, 8'h00, 8'h34}, 4, 16'h0);
        repeat (1022) @(negedge clk);
        send({8'h12}, 1, 16'h0);
        drain("rx_gap_ok");

        stall = 5;
        run_vec(vt[0], "stall_rd");
        run_vec(vt[1], "stall_wr");
        stall = 0;

        bus_q.push_back(mk_bus(1'b0, 16'h0040, 32'h0, 32'h12345678, 30));
        expect_reply({8'hAB}, 1);
        send({8'hAA, 8'h00, 8'h00, 8'h40, 8'h00}, 5, 16'h0);
        c = 0;
        while (!reg_req_o && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("req_seen", reg_req_o, 1'b1);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("req_async_drop", reg_req_o, 1'b0);
        check("reset_mid_outs", outs(), 64'h0);
        rpl_q.delete();
        bus_q.delete();
        @(negedge clk);
        check("reset_hold_outs", outs(), 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_vec(vt[2], "after_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_bridge.md
Name: reg_bridge

Overview:
Parametrised successor to the byte-stream register manager. Parses framed host commands from the FT2232 input byte stream and performs single or burst register reads/writes over a request/acknowledge register bus, with auto-incrementing or fixed addressing. Returns a fixed-length framed reply through the output mux. Adds bus-ack timeout, inter-byte receive timeout and a status byte.

Parameters:
ADDR_BYTES, 2, register address width in bytes (1..4); AW = 8*ADDR_BYTES
DATA_BYTES, 4, register data width in bytes (1..4); DW = 8*DATA_BYTES
REQ_MAGIC, 8'hAA, request frame start byte
RPL_MAGIC, 8'hAB, reply frame start byte
RX_TIMEOUT, 1024, max idle cycles between request bytes; 0 disables
BUS_TIMEOUT, 64, max cycles from reg_req_o rise to reg_ack_i (>=1)

Ports:
clk_i  in  1  clock
reset_ni  in  1  asynchronous active-low reset
in_rdy_i  in  1  in_data_i valid this cycle (one byte per cycle)
in_data_i  in  8  request byte
omux_req_o  out  1  reply byte valid
omux_data_o  out  8  reply byte; 8'h00 when omux_req_o low
omux_sel_i  in  1  reply byte consumed this cycle
reg_req_o  out  1  bus request, held until ack
reg_we_o  out  1  write when 1, read when 0; valid with reg_req_o
reg_addr_o  out  AW  bus address; stable while reg_req_o
reg_wdata_o  out  DW  write data; stable while reg_req_o
reg_rdata_i  in  DW  read data, sampled on reg_ack_i
reg_ack_i  in  1  single-cycle acknowledge

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters, error flags, address and data cleared. Asserting reset mid-transfer drops reg_req_o immediately. No reply is sent.
- Request frame: REQ_MAGIC, CMD, CNT, ADDR (ADDR_BYTES, LSB first). For writes, this is followed by (CNT+1) words of DATA_BYTES each, LSB first.
- CMD bit0 = write; bit1 = fixed address (no increment); bits7:2 must be 0.
- Words transferred = CNT+1 (1..256).
- States: IDLE, CMD, CNT, ADDR, WDATA, BUS, R_MAGIC, R_DATA, R_STATUS (+R_CSUM).
- IDLE: bytes other than REQ_MAGIC are ignored; REQ_MAGIC -> CMD.
- CMD:
  - Bits7:2 nonzero -> set status bit1 and go directly to R_MAGIC; the reply is RPL_MAGIC then status 8'h02.
  - Otherwise -> CNT.
- Write path: ADDR -> WDATA. On the last data byte of each word -> BUS. On ack -> WDATA for the next word, or R_MAGIC after the last word.
- Read path: ADDR -> R_MAGIC -> BUS -> R_DATA (DATA_BYTES bytes) -> BUS for the next word, or R_STATUS after the last word.
- BUS:
  - reg_req_o rises on the cycle after entering BUS and falls on the cycle after reg_ack_i.
  - rdata is latched on ack.
  - Minimum 2 cycles per word.
  - reg_ack_i outside BUS is ignored.
- Bus timeout: BUS_TIMEOUT cycles without ack -> drop req, set sticky status bit0, treat read data as 0.
- After a bus timeout, the remaining words of the frame issue no bus cycles. Write bytes are still consumed and read words are returned as zeros, so reply length is unchanged.
- Address: after each word, addr += 1 modulo 2^AW unless CMD bit1 is set. Wrap-around from all-ones to 0 is legal.
- Reply handshake: the byte is held on omux_data_o with omux_req_o high until omux_sel_i; it advances on the same edge. Back-to-back bytes are allowed.
- Reply contents:
  - Read: RPL_MAGIC, (CNT+1)*DATA_BYTES data bytes LSB first, status.
  - Write: RPL_MAGIC, status.
- Status byte: bit0 bus timeout, bit1 bad command, others 0. Cleared on entry to CMD.
- RX timeout: in CMD/CNT/ADDR/WDATA, RX_TIMEOUT consecutive cycles without in_rdy_i -> IDLE, no reply. The counter restarts on every accepted byte.
- in_rdy_i outside receive states is ignored; bytes are dropped with no backpressure.
- After R_STATUS (or R_CSUM) is consumed -> IDLE; a REQ_MAGIC on the same cycle is not captured.

Optional Feature:
REG_BRIDGE_CSUM_EN:
- Defined: after status, emit R_CSUM = XOR of all reply bytes following RPL_MAGIC, including status.
- Undefined: the R_CSUM state and its logic are absent; reply ends at status.

Decomposition:
- reg_bridge_pkg: state enum, CMD_WR_BIT=0, CMD_FIX_BIT=1, STAT_BUSTO_BIT=0, STAT_BADCMD_BIT=1, default magics.
- One sub-module: reg_bridge_timer, a loadable down-counter with an expire flag, instantiated twice (RX and bus timeouts). A timeout value of 0 holds expire low.

Test Plan:
1. Read: AA 00 00 34 12 with rdata=32'hDEADBEEF, ack after 3 cycles -> one access at addr 16'h1234, we=0; reply AB EF BE AD DE 00.
2. Burst write: AA 01 01 FF FF 11 22 33 44 55 66 77 88 -> writes 32'h44332211 @FFFF then 32'h88776655 @0000 (wrap); reply AB 00.
3. Fixed-address burst read: AA 02 02 10 00, three acks with 1,2,3 -> three reads at addr 0010; reply AB, data 1, 2, 3 (each LSB first), 00.
4. Bus timeout: read CNT=1 and never ack -> req drops after 64 cycles with no second access; reply AB + 8 zero bytes + 01.
5. Bad command and RX timeout:
   - AA 80 -> reply AB 02.
   - AA 00 00, then 1024 idle cycles -> back to IDLE, no reply; a following valid frame is serviced normally.
6. omux_sel_i stalled 5 cycles per byte, and reset_ni pulsed mid-BUS -> data held stable while stalled; after reset all outputs are 0 and reg_req_o drops asynchronously.
